// File: rtl/chip_seq_pkg.sv
// Shared constants for the chip test sequencer: state encoding, default
// parameter values and counter-width helpers.
package chip_seq_pkg;

    // Default configuration
    localparam int NUM_CHIPS_DEF      = 8;
    localparam int SEL_W_DEF          = 3;
    localparam int DB_CYCLES_DEF      = 50000;
    localparam int HOLD_CYCLES_DEF    = 25000000;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;

    // Sequencer state enumeration, 3-bit encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_SHOW    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Bits needed to hold values 0..max (never less than one bit)
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

    localparam int DB_W_DEF      = cnt_w(DB_CYCLES_DEF);
    localparam int HOLD_W_DEF    = cnt_w(HOLD_CYCLES_DEF);
    localparam int TIMEOUT_W_DEF = cnt_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/chip_test_sequencer_button_debounce.sv
// Start-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each rising edge of the debounced level.
module button_debounce
    import chip_seq_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn,
    output logic press
);

    localparam int W = cnt_w(DB_CYCLES);

    logic         sync1, sync2;
    logic         level;
    logic [W-1:0] cnt;

    // Synchronise, then flip the debounced level only after DB_CYCLES
    // consecutive cycles at the new value; pulse on a low-to-high flip.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == W'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip_test_sequencer.sv
// Chip test sequencer: launches the selected checker, qualifies its Done,
// latches Pass/Fail, holds them for display, then releases the checker.
// Optional watchdog on the Done wait is enabled with CHIP_SEQ_TIMEOUT_EN.
module chip_test_sequencer
    import chip_seq_pkg::*;
#(
    parameter int NUM_CHIPS      = NUM_CHIPS_DEF,
    parameter int SEL_W          = SEL_W_DEF,
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     Sel,
    input  logic [NUM_CHIPS-1:0] Done_in,
    input  logic [NUM_CHIPS-1:0] RSLT_in,
    output logic [NUM_CHIPS-1:0] Run_out,
    output logic                 DISP_RSLT,
    output logic                 Busy,
    output logic                 Pass,
    output logic                 Fail,
    output logic [SEL_W-1:0]     Cur_sel,
    output logic                 Timeout
);

    localparam int HOLD_W = cnt_w(HOLD_CYCLES);

    logic [2:0]        state;
    logic              press;
    logic              done_seen;
    logic [HOLD_W-1:0] hold_cnt;
    logic              done_sel, rslt_sel, latch_now;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .Clk   (Clk),
        .Reset (Reset),
        .btn   (Start),
        .press (press)
    );

    // Only the selected checker's handshake is ever looked at
    assign done_sel  = Done_in[Cur_sel];
    assign rslt_sel  = RSLT_in[Cur_sel];
    // Done must be high two cycles running; RSLT settles on the second
    assign latch_now = done_sel & done_seen;

`ifdef CHIP_SEQ_TIMEOUT_EN
    localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
    logic [TO_W-1:0] wd_cnt;
    logic            timeout_q;
    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    // Main sequencing FSM with result latch and hold counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Cur_sel   <= '0;
            Pass      <= 1'b0;
            Fail      <= 1'b0;
            done_seen <= 1'b0;
            hold_cnt  <= '0;
`ifdef CHIP_SEQ_TIMEOUT_EN
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press && (32'(Sel) < NUM_CHIPS)) begin
                        Cur_sel <= Sel;
                        Pass    <= 1'b0;
                        Fail    <= 1'b0;
`ifdef CHIP_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    done_seen <= 1'b0;
                    hold_cnt  <= '0;
`ifdef CHIP_SEQ_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    done_seen <= done_sel;
                    if (latch_now) begin
                        Pass  <= rslt_sel;
                        Fail  <= ~rslt_sel;
                        state <= ST_SHOW;
                    end
`ifdef CHIP_SEQ_TIMEOUT_EN
                    // A genuine Done on the expiry cycle takes priority
                    else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        Pass      <= 1'b0;
                        Fail      <= 1'b1;
                        state     <= ST_SHOW;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ST_SHOW: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1))
                        state <= ST_RELEASE;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                end
                ST_RELEASE: begin
                    if (!done_sel)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Run is a one-hot pulse for the single LAUNCH cycle
    always_comb begin
        Run_out = '0;
        if (state == ST_LAUNCH)
            Run_out[Cur_sel] = 1'b1;
    end

    assign Busy      = (state != ST_IDLE);
    assign DISP_RSLT = (state == ST_RELEASE);

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer with a result scoreboard.
// Define CHIP_SEQ_TIMEOUT_EN to also exercise the watchdog path.
module tb_chip_test_sequencer;

    localparam int NC = 8;
    localparam int SW = 3;

    logic          Clk = 1'b0;
    logic          Reset, Start;
    logic [SW-1:0] Sel;
    logic [NC-1:0] Done_in, RSLT_in, Run_out;
    logic          DISP_RSLT, Busy, Pass, Fail, Timeout;
    logic [SW-1:0] Cur_sel;

    chip_test_sequencer #(
        .NUM_CHIPS(NC), .SEL_W(SW), .DB_CYCLES(4),
        .HOLD_CYCLES(8), .TIMEOUT_CYCLES(100)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Sel(Sel),
        .Done_in(Done_in), .RSLT_in(RSLT_in), .Run_out(Run_out),
        .DISP_RSLT(DISP_RSLT), .Busy(Busy), .Pass(Pass), .Fail(Fail),
        .Cur_sel(Cur_sel), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [SW-1:0] sel;
        logic          pass;
        logic          fail;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Run-pulse monitor, sampled just after each rising edge
    int            cyc = 0;
    int            run_total = 0;
    int            run_time = 0;
    int            run_cnt[NC];
    logic [NC-1:0] last_run = '0;

    initial for (int k = 0; k < NC; k++) run_cnt[k] = 0;

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (Run_out != '0) begin
            run_total++;
            run_time = cyc;
            last_run = Run_out;
            for (int m = 0; m < NC; m++)
                if (Run_out[m]) run_cnt[m]++;
        end
    end

    initial begin
        repeat (20000) @(posedge Clk);
        $display("FAIL global_timeout observed=stuck required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit sig_hit(input int which);
        case (which)
            0:       return !Busy;
            1:       return DISP_RSLT;
            default: return Timeout;
        endcase
    endfunction

    // Bounded wait on a DUT condition; expiry shows up as a failed check
    task automatic wait_for(input string tag, input int which, input int max);
        int n = 0;
        while (!sig_hit(which) && n < max) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, 32'(sig_hit(which)), 32'd1);
    endtask

    task automatic press(input logic [SW-1:0] s);
        Sel   = s;
        Start = 1'b1;
        repeat (10) @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
    endtask

    task automatic push_exp(input logic [SW-1:0] s, input logic p, input logic f, input logic t);
        exp_t e;
        e.sel = s; e.pass = p; e.fail = f; e.to = t;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_cur_sel"}, 32'(Cur_sel), 32'(e.sel));
            chk({tag, "_pass"},    32'(Pass),    32'(e.pass));
            chk({tag, "_fail"},    32'(Fail),    32'(e.fail));
            chk({tag, "_timeout"}, 32'(Timeout), 32'(e.to));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run"},     32'(Run_out),   32'd0);
        chk({tag, "_disp"},    32'(DISP_RSLT), 32'd0);
        chk({tag, "_busy"},    32'(Busy),      32'd0);
        chk({tag, "_pass"},    32'(Pass),      32'd0);
        chk({tag, "_fail"},    32'(Fail),      32'd0);
        chk({tag, "_cur_sel"}, 32'(Cur_sel),   32'd0);
        chk({tag, "_timeout"}, 32'(Timeout),   32'd0);
    endtask

    int base;

    initial begin
        Reset = 1'b1; Start = 1'b0; Sel = '0; Done_in = '0; RSLT_in = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_all_zero("reset");

        // 1: normal pass on chip 3
        push_exp(3'd3, 1'b1, 1'b0, 1'b0);
        press(3'd3);
        chk("t1_run_count", 32'(run_total), 32'd1);
        chk("t1_run_value", 32'(last_run), 32'h08);
        chk("t1_busy", 32'(Busy), 32'd1);
        while (cyc < run_time + 20) @(negedge Clk);
        Done_in[3] = 1'b1; RSLT_in[3] = 1'b0;
        @(negedge Clk);
        chk("t1_no_latch_first_done", 32'(Pass | Fail), 32'd0);
        RSLT_in[3] = 1'b1;
        @(negedge Clk);
        chk("t1_pass", 32'(Pass), 32'd1);
        chk("t1_fail", 32'(Fail), 32'd0);
        repeat (7) @(negedge Clk);
        chk("t1_disp_before_hold", 32'(DISP_RSLT), 32'd0);
        @(negedge Clk);
        chk("t1_disp_after_hold", 32'(DISP_RSLT), 32'd1);
        @(negedge Clk);
        chk("t1_disp_held", 32'(DISP_RSLT), 32'd1);
        Done_in[3] = 1'b0;
        @(negedge Clk);
        chk("t1_disp_fall", 32'(DISP_RSLT), 32'd0);
        chk("t1_busy_fall", 32'(Busy), 32'd0);
        pop_check("t1");
        RSLT_in = '0;

        // 2: bouncing Start, fail on chip 5
        base = run_total;
        push_exp(3'd5, 1'b0, 1'b1, 1'b0);
        Sel = 3'd5;
        for (int b = 0; b < 6; b++) begin
            Start = ~Start;
            repeat (2) @(negedge Clk);
        end
        chk("t2_no_run_while_bouncing", 32'(run_total - base), 32'd0);
        Start = 1'b1;
        repeat (10) @(negedge Clk);
        chk("t2_run_count", 32'(run_total - base), 32'd1);
        chk("t2_run_value", 32'(last_run), 32'h20);
        Start = 1'b0;
        repeat (8) @(negedge Clk);

        // 3: busy lockout and unselected chips ignored during WAIT
        Sel = 3'd1; Start = 1'b1;
        repeat (10) @(negedge Clk);
        Done_in = 8'hDF; RSLT_in = 8'hDF;
        repeat (4) @(negedge Clk);
        chk("t3_no_run1", 32'(run_cnt[1]), 32'd0);
        chk("t3_cur_sel", 32'(Cur_sel), 32'd5);
        chk("t3_still_wait", 32'(Busy & ~(Pass | Fail)), 32'd1);
        Done_in = '0; RSLT_in = '0;
        Done_in[5] = 1'b1;
        repeat (2) @(negedge Clk);
        chk("t2_fail", 32'(Fail), 32'd1);
        wait_for("t2_disp", 1, 20);
        Done_in = '0;
        wait_for("t2_idle", 0, 5);
        pop_check("t2");
        repeat (15) @(negedge Clk);
        chk("t3_not_queued", 32'(run_total - base), 32'd1);
        chk("t3_idle", 32'(Busy), 32'd0);
        Start = 1'b0;
        repeat (8) @(negedge Clk);

        // 4: Done glitch on chip 2
        push_exp(3'd2, 1'b1, 1'b0, 1'b0);
        RSLT_in = 8'h04;
        press(3'd2);
        chk("t4_run", 32'(run_cnt[2]), 32'd1);
        Done_in[2] = 1'b1;
        @(negedge Clk);
        Done_in[2] = 1'b0;
        @(negedge Clk);
        chk("t4_glitch_ignored", 32'(Pass | Fail), 32'd0);
        Done_in[2] = 1'b1;
        @(negedge Clk);
        chk("t4_one_cycle_run", 32'(Pass), 32'd0);
        @(negedge Clk);
        chk("t4_pass", 32'(Pass), 32'd1);
        wait_for("t4_disp", 1, 20);
        Done_in = '0;
        wait_for("t4_idle", 0, 5);
        pop_check("t4");
        RSLT_in = '0;

        // 5: reset during SHOW, then a fresh launch
        RSLT_in = 8'h40;
        press(3'd6);
        Done_in = 8'h40;
        repeat (2) @(negedge Clk);
        chk("t5_pass_before_reset", 32'(Pass), 32'd1);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk_all_zero("t5_reset");
        Done_in = '0; RSLT_in = '0;
        @(negedge Clk);
        push_exp(3'd7, 1'b0, 1'b1, 1'b0);
        press(3'd7);
        chk("t5_relaunch", 32'(run_cnt[7]), 32'd1);
        Done_in = 8'h80;
        wait_for("t5_disp", 1, 20);
        Done_in = '0;
        wait_for("t5_idle", 0, 5);
        pop_check("t5");

        // 6: Done never arrives
`ifdef CHIP_SEQ_TIMEOUT_EN
        push_exp(3'd4, 1'b0, 1'b1, 1'b1);
        press(3'd4);
        wait_for("t6_timeout", 2, 200);
        chk("t6_timeout_cycle", 32'(cyc - run_time), 32'd101);
        chk("t6_fail", 32'(Fail), 32'd1);
        wait_for("t6_disp", 1, 20);
        wait_for("t6_idle", 0, 5);
        pop_check("t6");
`else
        press(3'd4);
        repeat (150) @(negedge Clk);
        chk("t6_busy_forever", 32'(Busy), 32'd1);
        chk("t6_no_timeout", 32'(Timeout), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/chip_test_sequencer.md
Name: chip_test_sequencer

Overview:
Control stage directly upstream and downstream of the per-chip checker blocks.
- Takes the user's Start button and chip-select switches.
- Launches the selected checker with a one-cycle Run pulse and waits for its Done.
- Latches the checker's RSLT into Pass/Fail indicators, holds them for a display interval, then pulses DISP_RSLT to return the checker to Halted.

Parameters:
NUM_CHIPS, 8, number of checker slots driven by this sequencer
SEL_W, 3, width of chip-select field (ceil log2 NUM_CHIPS)
DB_CYCLES, 50000, stable cycles required before Start is accepted as pressed
HOLD_CYCLES, 25000000, cycles Pass/Fail are held before DISP_RSLT is issued
TIMEOUT_CYCLES, 1000000, max cycles waiting for Done (used only with TIMEOUT_EN)

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high; clears all state and outputs
Start  input  1  raw, asynchronous pushbutton (high = pressed); double-flop synchronised internally
Sel  input  SEL_W  chip-select switches; sampled only on accepted Start
Done_in  input  NUM_CHIPS  Done from each checker
RSLT_in  input  NUM_CHIPS  RSLT from each checker
Run_out  output  NUM_CHIPS  one-hot Run to checkers
DISP_RSLT  output  1  release strobe, shared by all checkers
Busy  output  1  high from accepted Start until return to IDLE
Pass  output  1  latched result = 1
Fail  output  1  latched result = 0
Cur_sel  output  SEL_W  chip index of the last launched test
Timeout  output  1  watchdog expired (tied 0 without TIMEOUT_EN)

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-test aborts immediately; the checker is not released.
- Debounce: the synchronised Start must hold a new level for DB_CYCLES consecutive cycles before the debounced level changes.
- An accepted press is a rising edge of the debounced level. Holding the button yields one press; a new test requires release and re-press.
- IDLE:
  - Pass/Fail/Timeout keep their last values.
  - On an accepted press with Sel < NUM_CHIPS: latch Sel into Cur_sel, clear Pass/Fail/Timeout, go to LAUNCH.
  - Sel >= NUM_CHIPS: press ignored, stay IDLE.
- LAUNCH (1 cycle): Run_out[Cur_sel] = 1, Busy = 1. Next cycle go to WAIT.
- WAIT: Run_out = 0. The selected Done_in must be high for 2 consecutive cycles, because the checker asserts Done combinationally one cycle before its RSLT settles.
  - On the 2nd consecutive high cycle: Pass = RSLT_in[Cur_sel], Fail = ~RSLT_in[Cur_sel], go to SHOW.
  - A single-cycle Done glitch resets the run-length count.
- SHOW: count HOLD_CYCLES cycles; Pass/Fail held. Go to RELEASE.
- RELEASE: DISP_RSLT = 1 until Done_in[Cur_sel] reads 0, then DISP_RSLT = 0, Busy = 0, go to IDLE. Pass/Fail stay latched.
- Sel or Start changes while Busy are ignored. A press that completes debounce while Busy is discarded, not queued.
- Done_in/RSLT_in bits of non-selected chips are never examined.
- Counters saturate and do not wrap. Watchdog counter width = clog2(TIMEOUT_CYCLES+1).

Optional Feature:
Macro CHIP_SEQ_TIMEOUT_EN.
- Defined: the watchdog counts cycles in WAIT. On reaching TIMEOUT_CYCLES: Timeout = 1, Fail = 1, Pass = 0, go to SHOW; RELEASE proceeds normally.
- Undefined: WAIT has no time limit, the Timeout output is tied 0, and no watchdog counter is synthesised.

Decomposition:
- Package chip_seq_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, SHOW, RELEASE), 3-bit encoding;
  - default parameter constants;
  - clog2-based width constants.
- Sub-module button_debounce (parameter DB_CYCLES): holds the 2-flop synchroniser, stability counter and rising-edge pulse output. It is instantiated once.

Test Plan:
Bench parameters for all scenarios: DB_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=100, NUM_CHIPS=8.
1. Normal pass:
   - Stimulus: Sel=3, Start high 10 cycles; model checker raises Done_in[3] 20 cycles after Run, with RSLT_in[3]=1 from the 2nd Done cycle.
   - Response: Run_out=8'h08 for exactly 1 cycle; Pass=1, Fail=0; DISP_RSLT rises 8 cycles later and falls the cycle after Done_in[3] drops; Busy=0.
2. Fail with bounce:
   - Stimulus: Start toggles every 2 cycles for 12 cycles, then steady high; Sel=5; RSLT_in[5]=0.
   - Response: exactly one Run_out=8'h20 pulse; Fail=1.
3. Busy lockout: change Sel to 1 and re-press Start during WAIT -> no Run_out[1] pulse; Cur_sel stays 5; press not queued after IDLE.
4. Done glitch: Done_in[2] high 1 cycle, low, high 2 cycles -> result latched only on the 2-cycle run.
5. Reset mid-SHOW: Reset high 1 cycle -> all outputs 0 on the next edge; state IDLE; a subsequent press launches normally.
6. Timeout (CHIP_SEQ_TIMEOUT_EN defined): Done_in never rises -> Timeout=1 and Fail=1 exactly 100 cycles into WAIT, then DISP_RSLT pulse. With the macro undefined, Busy stays high indefinitely.
